// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
// Holds funct3 codes, the lsu_master state enum, and size/legality decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        DONE
    } state_t;

    // Access size in bytes (1/2/4) from funct3[1:0].
    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Unsigned variants exist only for loads.
    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane steering for lsu_master.
// Ports: size_i/off_i/funct3_i describe the access; wdata_i is right-aligned
// store data; lo_i/hi_i are the captured read words. be_o/wd_o are the
// 64-bit (two-beat) byte enables and shifted store data; rdata_o is the
// realigned, extended load result.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] hi_i,
    output logic [7:0]  be_o,
    output logic [63:0] wd_o,
    output logic [31:0] rdata_o
);

    logic [31:0] raw;

    always_comb begin
        be_o = ((8'd1 << size_i) - 8'd1) << off_i;
        wd_o = {32'd0, wdata_i} << {off_i, 3'b000};
        raw  = 32'({hi_i, lo_i} >> {off_i, 3'b000});
        case (funct3_i)
            F3_B:    rdata_o = {{24{raw[7]}}, raw[7:0]};
            F3_H:    rdata_o = {{16{raw[15]}}, raw[15:0]};
            F3_W:    rdata_o = raw;
            F3_BU:   rdata_o = {24'd0, raw[7:0]};
            F3_HU:   rdata_o = {16'd0, raw[15:0]};
            default: rdata_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_master.sv
// RV32I load/store initiator: turns pipeline requests into word-aligned bus
// beats with byte enables, splitting word-crossing accesses when the macro
// LSU_SPLIT_CROSS_EN is defined (otherwise crossing accesses fault).
// Ports: clk/rst (sync, active-high); req_* pipeline request, held until done;
// idle/done/fault/rdata completion; mem_* registered bus beat, mem_ready and
// mem_rdata from memory.
module lsu_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              idle,
    output logic              done,
    output logic              fault,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

`ifdef LSU_SPLIT_CROSS_EN
    localparam logic SplitEn = 1'b1;
`else
    localparam logic SplitEn = 1'b0;
`endif

    state_t state_q, state_d;

    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              cross_q;
    logic              fault_q;
    logic [31:0]       lo_q;
    logic [31:0]       hi_q;

    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;

    logic [2:0]        req_size;
    logic              req_cross;
    logic              req_fault;
    logic              beat_ack;
    logic [ADDR_W-1:0] base;
    logic [7:0]        be64;
    logic [63:0]       wd64;
    logic [31:0]       ld_data;

    // Decode of the incoming request, used only at acceptance.
    always_comb begin
        req_size  = size_of(req_funct3);
        req_cross = ({2'b00, req_addr[1:0]} + {1'b0, req_size}) > 4'd4;
        req_fault = !is_legal(req_we, req_funct3) || (req_cross && !SplitEn);
    end

    assign beat_ack = mem_req_q && mem_ready;
    assign base     = {addr_q[ADDR_W-1:2], 2'b00};

    lsu_lane u_lane (
        .size_i  (size_of(f3_q)),
        .off_i   (addr_q[1:0]),
        .funct3_i(f3_q),
        .wdata_i (wdata_q),
        .lo_i    (lo_q),
        .hi_i    (hi_q),
        .be_o    (be64),
        .wd_o    (wd64),
        .rdata_o (ld_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = req_fault ? DONE : BEAT0;
                end
            end
            BEAT0: begin
                if (beat_ack) begin
                    state_d = cross_q ? BEAT1 : DONE;
                end
            end
            BEAT1: begin
                if (beat_ack) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        idle      = (state_q == IDLE);
        done      = (state_q == DONE);
        fault     = done && fault_q;
        rdata     = (done && !we_q && !fault_q) ? ld_data : '0;
        mem_req   = mem_req_q;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_be    = mem_be_q;
        mem_wdata = mem_wdata_q;
    end

    // Request latch and read-word capture
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            cross_q <= 1'b0;
            fault_q <= 1'b0;
            lo_q    <= 32'd0;
            hi_q    <= 32'd0;
        end else if (state_q == IDLE) begin
            if (req_valid) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cross_q <= req_cross;
                fault_q <= req_fault;
                lo_q    <= 32'd0;
                hi_q    <= 32'd0;
            end
        end else if (beat_ack) begin
            if (state_q == BEAT0) begin
                lo_q <= mem_rdata;
            end else begin
                hi_q <= mem_rdata;
            end
        end
    end

    // Bus beat registers: loaded one cycle after entering a beat state
    // (lane data comes from the latched request), held until mem_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
        end else if (beat_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
        end else if (!mem_req_q && state_q == BEAT0) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= we_q;
            mem_addr_q  <= base;
            mem_be_q    <= be64[3:0];
            mem_wdata_q <= wd64[31:0];
        end else if (!mem_req_q && state_q == BEAT1) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= we_q;
            mem_addr_q  <= base + ADDR_W'(4);
            mem_be_q    <= be64[7:4];
            mem_wdata_q <= wd64[63:32];
        end
    end

endmodule
